lut_config_loader: RTL and testbench
====================================

# lut_config_loader

Sequencer that programs a bank of `block_config_latches` LUT memories from a narrow configuration stream. It assembles each LUT's `MEM_SIZE`-bit truth table from `IN_WIDTH`-bit chunks and drives a shared `config_out` bus. It then strobes exactly one `comb_set` line with setup and hold margins, because the target latches are level-sensitive. It sits between the fabric's configuration port and the `SLICEL` LUT blocks.

## Interface
Parameters:
- `ADDR_BITS`, 4: LUT address width.
- `MEM_SIZE`, `2**ADDR_BITS`: bits per LUT.
- `NUM_LUTS`, 8: number of LUT blocks programmed per load.
- `IN_WIDTH`, 4: stream chunk width. `MEM_SIZE % IN_WIDTH == 0` is required.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a load sequence; sampled only in IDLE.
- `in_data`, in, `IN_WIDTH`: configuration chunk, MSB-first within each LUT word.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a chunk this cycle.
- `in_parity`, in, 1: expected even parity of the current word; sampled with its last chunk.
- `config_out`, out, `MEM_SIZE`: shared `config_in` bus to all LUT blocks.
- `comb_set`, out, `NUM_LUTS`: one-hot write strobes, one per LUT block.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of a sequence.
- `err`, out, 1: sticky parity error flag.

## Operation
- Reset values:
  - State: IDLE.
  - `in_ready`, `comb_set`, `busy`, `done`, `err`: 0.
  - `config_out`: 0.
  - LUT index and chunk count: 0.
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE.
- IDLE: on `start`, move to LOAD; LUT index = 0, chunk count = 0, `err` = 0.
- LOAD:
  - `in_ready` = 1.
  - On each `in_valid & in_ready`: `config_out <= {config_out[MEM_SIZE-IN_WIDTH-1:0], in_data}` and the chunk count increments.
  - On accepting chunk number `MEM_SIZE/IN_WIDTH`: chunk count clears and the state moves to SETUP.
- SETUP: `config_out` is frozen; `comb_set` = 0.
- STROBE: `comb_set[idx]` = 1 for exactly this cycle; all other bits are 0.
- HOLD: `config_out` is frozen; `comb_set` = 0.
  - If `idx == NUM_LUTS-1`, move to DONE.
  - Otherwise `idx++` and move to LOAD.
- DONE: `done` = 1 for this cycle only, then move to IDLE.
- `config_out` changes only in LOAD, on accepted chunks.
- `comb_set` is never high in LOAD, SETUP or HOLD.
- `start` is ignored outside IDLE. `start` arriving in the same cycle as the DONE pulse is ignored.
- Stalls: with `in_valid` low, the block stays in LOAD indefinitely with no timeout.
- Reset mid-operation:
  - Any `comb_set` is low from the first cycle after the reset edge.
  - A partially assembled word is discarded.
  - LUTs already written keep their contents; the loader does not touch them.

## Timing
- `in_ready` is combinational from state only; it does not depend on `in_valid`.
- Last chunk accepted at edge k: SETUP in cycle k+1, STROBE in k+2, HOLD in k+3, next LOAD (or DONE) in k+4.
- Per LUT, with a continuous stream: `MEM_SIZE/IN_WIDTH + 3` cycles.
- Defaults: 7 cycles per LUT; full sequence 56 cycles plus 1 DONE cycle.
- `config_out` is stable at least 1 cycle before, during, and 1 cycle after each strobe.

## Configuration
- Macro: `LUT_CONFIG_PARITY_EN`.
- Defined:
  - The loader computes even parity over the assembled word, including the last chunk.
  - On mismatch with `in_parity`, STROBE is replaced by an idle cycle (`comb_set` stays 0) and `err` is set.
  - `err` holds until the next accepted `start` or `rst`.
  - Timing and sequencing are otherwise unchanged; the loader continues to the next LUT.
- Undefined: `in_parity` is ignored and `err` is tied to 0.

## Structure
- Shared package `lut_cfg_pkg`:
  - State enum `lut_cfg_state_t`.
  - Localparam `CHUNKS_PER_LUT = MEM_SIZE/IN_WIDTH`.
  - Index-width helper for `NUM_LUTS`.
- Sub-module `lut_cfg_shifter`: the `MEM_SIZE`-bit chunk shift register, chunk counter, `word_full` flag and parity accumulator.
- The FSM and one-hot strobe decode live in the top level.

## Test plan
- Reset, then one `start`; stream 32 chunks with `in_valid` always high, LUT *i* data = `16'hA5A0 | i` → `comb_set` goes 0x01, 0x02, …, 0x80, one cycle each and 7 cycles apart. `config_out` equals the LUT *i* word during each strobe, and `done` pulses at cycle 57.
- Deassert `in_valid` for 5 cycles mid-word on LUT 3 → no `comb_set` during the stall; LUT 3 strobe is delayed by exactly 5 cycles and its data is correct.
- Assert `rst` during STROBE of LUT 2 → `comb_set` = 0 next cycle, `busy` = 0, `config_out` = 0. A new `start` then programs from LUT 0.
- Pulse `start` during LOAD and during DONE → ignored; exactly 8 strobes and 1 `done` pulse.
- With `LUT_CONFIG_PARITY_EN`, give a wrong `in_parity` on LUT 5 → no `comb_set[5]` pulse and `err` = 1 through `done`. The other 7 LUTs are written normally, and `err` clears on the next `start`.
- Without the macro, the same stimulus → `comb_set[5]` pulses and `err` stays 0.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration loader.
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } lut_cfg_state_t;

    localparam int DEF_ADDR_BITS  = 4;
    localparam int DEF_MEM_SIZE   = 2 ** DEF_ADDR_BITS;
    localparam int DEF_NUM_LUTS   = 8;
    localparam int DEF_IN_WIDTH   = 4;
    localparam int CHUNKS_PER_LUT = DEF_MEM_SIZE / DEF_IN_WIDTH;

    // Width of an index able to address n items (never less than one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Assembles one LUT truth table from MSB-first stream chunks, counts chunks
// and keeps a running even-parity of the word being built.
module lut_cfg_shifter
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int IN_WIDTH = DEF_IN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic [MEM_SIZE-1:0] word,
    output logic                word_full,
    output logic                word_parity
);

    localparam int CHUNKS = MEM_SIZE / IN_WIDTH;
    localparam int CNT_W  = idx_bits(CHUNKS);

    logic [CNT_W-1:0] chunk_cnt;
    logic             parity_acc;

    // word_full marks the cycle the last chunk of a word is being accepted
    assign word_full   = shift_en && (chunk_cnt == CNT_W'(CHUNKS - 1));
    // parity includes the chunk currently on the bus
    assign word_parity = parity_acc ^ (^in_data);

    // Shift register, chunk counter and parity accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            word       <= '0;
            chunk_cnt  <= '0;
            parity_acc <= 1'b0;
        end else if (shift_en) begin
            word <= {word[MEM_SIZE-IN_WIDTH-1:0], in_data};
            if (word_full) begin
                chunk_cnt  <= '0;
                parity_acc <= 1'b0;
            end else begin
                chunk_cnt  <= chunk_cnt + 1'b1;
                parity_acc <= word_parity;
            end
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// Programs a bank of level-sensitive LUT latches from a narrow stream:
// assemble a word, hold it one cycle, strobe one comb_set line, hold again.
// Optional build macro LUT_CONFIG_PARITY_EN: per-word even-parity check that
// suppresses the strobe of a bad word and raises a sticky err flag.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD      | accepting stream chunks for LUT idx
// SETUP     | word frozen, latch inputs settle
// STROBE    | comb_set[idx] high for one cycle
// HOLD      | word frozen after strobe, then next LUT or DONE
// DONE      | one-cycle done pulse
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int MEM_SIZE  = 2 ** ADDR_BITS,
    parameter int NUM_LUTS  = DEF_NUM_LUTS,
    parameter int IN_WIDTH  = DEF_IN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_parity,
    output logic [MEM_SIZE-1:0] config_out,
    output logic [NUM_LUTS-1:0] comb_set,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IDX_W = idx_bits(NUM_LUTS);

    lut_cfg_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             word_full;
    logic             word_parity;
    logic             par_bad;
    logic             last_lut;

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign last_lut = (idx_q == IDX_W'(NUM_LUTS - 1));

    lut_cfg_shifter #(
        .MEM_SIZE (MEM_SIZE),
        .IN_WIDTH (IN_WIDTH)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (in_valid && in_ready),
        .in_data     (in_data),
        .word        (config_out),
        .word_full   (word_full),
        .word_parity (word_parity)
    );

`ifdef LUT_CONFIG_PARITY_EN
    logic par_bad_q;
    logic err_q;

    assign par_bad = par_bad_q;
    assign err     = err_q;

    // Latch the parity verdict with the last chunk; err sticks until a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (word_full)
                par_bad_q <= (word_parity != in_parity);
            if (state_q == ST_IDLE && start)
                err_q <= 1'b0;
            else if (state_q == ST_SETUP && par_bad_q)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_parity;

    assign unused_parity = word_parity ^ in_parity;
    assign par_bad       = 1'b0;
    assign err           = 1'b0;
`endif

    // State register and LUT index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start)
                idx_q <= '0;
            else if (state_q == ST_HOLD && !last_lut)
                idx_q <= idx_q + 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (word_full) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = last_lut ? ST_DONE : ST_LOAD;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // One-hot strobe; a word that failed parity gets an idle cycle instead
    always_comb begin
        comb_set = '0;
        if (state_q == ST_STROBE && !par_bad)
            comb_set = NUM_LUTS'(1) << idx_q;
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a schedule model derived from the
// cycle arithmetic of a load sequence predicts every output on every cycle.
module tb_lut_config_loader;

    localparam int NL = 8;

`ifdef LUT_CONFIG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_parity, busy, done, err;
    logic [3:0]  in_data;
    logic [15:0] config_out;
    logic [7:0]  comb_set;

    lut_config_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_parity  (in_parity),
        .config_out (config_out),
        .comb_set   (comb_set),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // schedule model of the running sequence
    int          lw [0:NL-1];
    int          dl [0:NL-1];
    int          sc [0:NL-1];
    int          dcyc;
    int          bad;
    int          stpos;
    logic [15:0] base;
    bit          seq_active = 1'b0;
    bit          chk_en = 1'b0;
    int          gcyc = 0;
    int          seq_base = 0;
    logic [15:0] idle_cfg = 16'h0;
    bit          err_hold = 1'b0;

    // observations used by the literal pins
    int          strobe_cnt, done_cnt, obs_done;
    int          obs_sc [0:NL-1];
    logic [15:0] obs_data [0:NL-1];
    logic        obs_err_done;

    always @(posedge clk) gcyc <= gcyc + 1;

    function automatic logic [15:0] word_of(input int i);
        return base | 16'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // per-cycle comparison against the schedule model
    always @(negedge clk) begin
        int          c;
        logic [7:0]  ecs;
        logic [15:0] ecfg;
        bit          cchk, erdy, ebusy, edone, eerr;
        if (chk_en) begin
            if (!seq_active) begin
                ebusy = 1'b0; edone = 1'b0; erdy = 1'b0; ecs = 8'h0;
                ecfg = idle_cfg; cchk = 1'b1; eerr = err_hold;
            end else begin
                c     = gcyc - seq_base;
                ebusy = (c >= 1 && c <= dcyc);
                edone = (c == dcyc);
                erdy  = 1'b0; ecs = 8'h0; cchk = 1'b0; ecfg = 16'h0;
                if (c == 0) begin cchk = 1'b1; ecfg = idle_cfg; end
                if (c >= dcyc) begin cchk = 1'b1; ecfg = word_of(NL - 1); end
                for (int i = 0; i < NL; i++) begin
                    if (c >= lw[i] && c <= lw[i] + 3 + dl[i]) erdy = 1'b1;
                    if (c >= sc[i] - 1 && c <= sc[i] + 1) begin
                        cchk = 1'b1;
                        ecfg = word_of(i);
                    end
                    if (c == sc[i] && !(PAR_EN && i == bad)) ecs = 8'(1 << i);
                end
                eerr = 1'b0;
                if (c == 0) eerr = err_hold;
                else if (PAR_EN && bad >= 0) begin
                    if (c >= sc[bad]) eerr = 1'b1;
                end
                if (comb_set != 8'h0) strobe_cnt = strobe_cnt + 1;
                for (int i = 0; i < NL; i++) begin
                    if (comb_set[i]) begin
                        obs_sc[i]   = c;
                        obs_data[i] = config_out;
                    end
                end
                if (done) begin
                    done_cnt     = done_cnt + 1;
                    obs_done     = c;
                    obs_err_done = err;
                end
            end
            chk("busy", 32'(busy), 32'(ebusy));
            chk("done", 32'(done), 32'(edone));
            chk("in_ready", 32'(in_ready), 32'(erdy));
            chk("comb_set", 32'(comb_set), 32'(ecs));
            chk("err", 32'(err), 32'(eerr));
            if (cchk) chk("config_out", 32'(config_out), 32'(ecfg));
        end
    end

    // drive the stream for sequence-relative cycle c
    task automatic drive_data(input int c);
        int          o, j;
        logic [15:0] w;
        in_valid  = 1'b1;
        in_data   = 4'hF;
        in_parity = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (c >= lw[i] && c <= lw[i] + 3 + dl[i]) begin
                o = c - lw[i];
                if (o < stpos) j = o;
                else if (o < stpos + dl[i]) j = -1;
                else j = o - dl[i];
                w = word_of(i);
                if (j < 0) begin
                    in_valid = 1'b0;
                end else begin
                    in_data   = w[15-4*j -: 4];
                    in_parity = (^w) ^ (i == bad);
                end
            end
        end
    endtask

    task automatic run_seq(input logic [15:0] b, input int st_lut, input int st_pos,
                           input int st_len, input int bad_i, input int ld_start_c,
                           input bit done_start, input int abort_c);
        int L;
        bit aborted;
        base  = b;
        bad   = bad_i;
        stpos = st_pos;
        L     = 1;
        for (int i = 0; i < NL; i++) begin
            lw[i]       = L;
            dl[i]       = (i == st_lut) ? st_len : 0;
            sc[i]       = L + 5 + dl[i];
            L           = L + 7 + dl[i];
            obs_sc[i]   = -1;
            obs_data[i] = 16'h0;
        end
        dcyc         = L;
        strobe_cnt   = 0;
        done_cnt     = 0;
        obs_done     = -1;
        obs_err_done = 1'bx;
        aborted      = 1'b0;
        for (int c = 0; c <= dcyc + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                seq_base   = gcyc;
                seq_active = 1'b1;
            end
            start = (c == 0) || (c == ld_start_c) || (done_start && c == dcyc);
            drive_data(c);
            if (c == abort_c) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        if (aborted) begin
            idle_cfg = 16'h0;
            err_hold = 1'b0;
        end else begin
            idle_cfg = word_of(NL - 1);
            err_hold = PAR_EN && (bad >= 0);
        end
        seq_active = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_parity = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_comb_set", 32'(comb_set), 32'h0);
        chk("rst_config_out", 32'(config_out), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // continuous stream, no disturbances
        run_seq(16'hA5A0, -1, 0, 0, -1, -1, 1'b0, -1);
        chk("A_done_cycle", 32'(obs_done), 32'd57);
        chk("A_strobes", 32'(strobe_cnt), 32'd8);
        chk("A_lut0_cycle", 32'(obs_sc[0]), 32'd6);
        chk("A_lut7_cycle", 32'(obs_sc[7]), 32'd55);
        chk("A_lut0_data", 32'(obs_data[0]), 32'hA5A0);
        chk("A_lut7_data", 32'(obs_data[7]), 32'hA5A7);

        // 5-cycle stall inside LUT 3, start pulsed in LOAD and in DONE
        run_seq(16'h3C50, 3, 2, 5, -1, 3, 1'b1, -1);
        chk("B_lut2_cycle", 32'(obs_sc[2]), 32'd20);
        chk("B_lut3_cycle", 32'(obs_sc[3]), 32'd32);
        chk("B_lut4_cycle", 32'(obs_sc[4]), 32'd39);
        chk("B_lut3_data", 32'(obs_data[3]), 32'h3C53);
        chk("B_done_cycle", 32'(obs_done), 32'd62);
        chk("B_strobes", 32'(strobe_cnt), 32'd8);
        chk("B_done_pulses", 32'(done_cnt), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // reset during the LUT 2 strobe
        run_seq(16'h5A00, -1, 0, 0, -1, -1, 1'b0, 20);
        chk("C_strobes", 32'(strobe_cnt), 32'd3);
        chk("C_done_pulses", 32'(done_cnt), 32'd0);
        @(negedge clk);
        chk("C_after_rst_busy", 32'(busy), 32'h0);
        chk("C_after_rst_cfg", 32'(config_out), 32'h0);
        @(posedge clk); #1;

        // wrong parity on LUT 5
        run_seq(16'hC3F0, -1, 0, 0, 5, -1, 1'b0, -1);
        chk("D_strobes", 32'(strobe_cnt), PAR_EN ? 32'd7 : 32'd8);
        chk("D_lut5_cycle", 32'(obs_sc[5]), PAR_EN ? 32'hFFFF_FFFF : 32'd41);
        chk("D_lut6_data", 32'(obs_data[6]), 32'hC3F6);
        chk("D_err_at_done", 32'(obs_err_done), PAR_EN ? 32'd1 : 32'd0);

        // clean sequence after the error: err must clear on start
        run_seq(16'h0F10, -1, 0, 0, -1, -1, 1'b0, -1);
        chk("E_err_at_done", 32'(obs_err_done), 32'd0);
        chk("E_strobes", 32'(strobe_cnt), 32'd8);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
